// File: rtl/sqrt_handshake_responder.sv
// ============================================================================
// Module      : sqrt_handshake_responder
// Description : Strobe/ack handshake front-end for a start/done square-root
//               core. Define SQRT_REQ_QUEUE_EN to add a 2-entry request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_handshake_responder #(
  parameter int SIZE       = 64,
  parameter int FLOAT_SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            isInputStable,
  input  logic [SIZE-1:0] in,
  input  logic            isFloat,
  output logic [SIZE-1:0] result,
  output logic            isResultStable,
  input  logic            resultAck,
  output logic            busy,
  output logic            reqDropped,
  output logic            coreStart,
  output logic [SIZE-1:0] coreIn,
  output logic            coreIsFloat,
  input  logic            coreDone,
  input  logic [SIZE-1:0] coreResult
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LAUNCH      = 2'd1,
    WAIT_CORE   = 2'd2,
    HOLD_RESULT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] op_q, op_d;
  logic            op_float_q, op_float_d;
  logic [SIZE-1:0] result_q, result_d;
  logic            dropped_q, dropped_d;

  logic [SIZE-1:0] in_op;
  logic [SIZE-1:0] core_res_masked;
  logic            req_while_busy;
  logic            ack_in_hold;

  // Float operands only ever carry the low FLOAT_SIZE bits towards the core.
  assign in_op           = isFloat    ? {{(SIZE-FLOAT_SIZE){1'b0}}, in[FLOAT_SIZE-1:0]}
                                      : in;
  assign core_res_masked = op_float_q ? {{(SIZE-FLOAT_SIZE){1'b0}}, coreResult[FLOAT_SIZE-1:0]}
                                      : coreResult;
  assign req_while_busy  = isInputStable && (state_q != IDLE);
  assign ack_in_hold     = resultAck && (state_q == HOLD_RESULT);

`ifdef SQRT_REQ_QUEUE_EN
  logic [SIZE-1:0] fifo_op_q  [2];
  logic [SIZE-1:0] fifo_op_d  [2];
  logic            fifo_flt_q [2];
  logic            fifo_flt_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            fifo_full;
  logic            accept;
  logic            bypass;
  logic            pop;
  logic            wr_idx;

  assign fifo_full = (count_q == 2'd2);
  assign accept    = req_while_busy && !fifo_full;
  assign pop       = ack_in_hold && (count_q != 2'd0);
  // Request arriving with the ack into an empty FIFO goes straight to launch.
  assign bypass    = ack_in_hold && (count_q == 2'd0) && accept;
  assign wr_idx    = rd_ptr_q ^ count_q[0];
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_float_d = op_float_q;
    result_d   = result_q;
    dropped_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (isInputStable) begin
          op_d       = in_op;
          op_float_d = isFloat;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (coreDone) begin
          result_d = core_res_masked;
          state_d  = HOLD_RESULT;
        end
      end
      HOLD_RESULT: begin
        if (resultAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SQRT_REQ_QUEUE_EN
    fifo_op_d  = fifo_op_q;
    fifo_flt_d = fifo_flt_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dropped_d  = req_while_busy && fifo_full;

    if (pop) begin
      op_d       = fifo_op_q[rd_ptr_q];
      op_float_d = fifo_flt_q[rd_ptr_q];
      state_d    = LAUNCH;
      rd_ptr_d   = ~rd_ptr_q;
    end else if (bypass) begin
      op_d       = in_op;
      op_float_d = isFloat;
      state_d    = LAUNCH;
    end

    if (accept && !bypass) begin
      fifo_op_d[wr_idx]  = in_op;
      fifo_flt_d[wr_idx] = isFloat;
    end

    count_d = count_q + {1'b0, (accept && !bypass)} - {1'b0, pop};
`else
    dropped_d = req_while_busy;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      op_float_q <= 1'b0;
      result_q   <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_float_q <= op_float_d;
      result_q   <= result_d;
      dropped_q  <= dropped_d;
    end
  end

`ifdef SQRT_REQ_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_op_q[0]  <= '0;
      fifo_op_q[1]  <= '0;
      fifo_flt_q[0] <= 1'b0;
      fifo_flt_q[1] <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      fifo_op_q  <= fifo_op_d;
      fifo_flt_q <= fifo_flt_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
`endif

  assign result         = result_q;
  assign isResultStable = (state_q == HOLD_RESULT);
  assign busy           = (state_q != IDLE);
  assign reqDropped     = dropped_q;
  assign coreStart      = (state_q == LAUNCH);
  assign coreIn         = op_q;
  assign coreIsFloat    = op_float_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_handshake_responder.sv
// ============================================================================
// Module      : tb_sqrt_handshake_responder
// Description : Scoreboard bench for sqrt_handshake_responder with a
//               3-cycle XOR core stub. Honours SQRT_REQ_QUEUE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sqrt_handshake_responder;

  localparam int SIZE       = 64;
  localparam int FLOAT_SIZE = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            isInputStable;
  logic [SIZE-1:0] op_in;
  logic            isFloat;
  logic [SIZE-1:0] result;
  logic            isResultStable;
  logic            resultAck;
  logic            busy;
  logic            reqDropped;
  logic            coreStart;
  logic [SIZE-1:0] coreIn;
  logic            coreIsFloat;
  logic            coreDone;
  logic [SIZE-1:0] coreResult;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  logic [SIZE-1:0] sb[$];

  sqrt_handshake_responder #(.SIZE(SIZE), .FLOAT_SIZE(FLOAT_SIZE)) dut (
    .clk(clk), .rst(rst), .isInputStable(isInputStable), .in(op_in),
    .isFloat(isFloat), .result(result), .isResultStable(isResultStable),
    .resultAck(resultAck), .busy(busy), .reqDropped(reqDropped),
    .coreStart(coreStart), .coreIn(coreIn), .coreIsFloat(coreIsFloat),
    .coreDone(coreDone), .coreResult(coreResult)
  );

  always #5 clk = ~clk;

  // Core stub: done pulse 3 cycles after start; deliberately not reset.
  int              stub_cnt = 0;
  logic [SIZE-1:0] stub_res = '0;
  always @(posedge clk) begin
    if (coreStart === 1'b1) begin
      stub_cnt <= 3;
      stub_res <= coreIn ^ 64'hFF;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign coreDone   = (stub_cnt == 1);
  assign coreResult = stub_res;

  always @(negedge clk) if (reqDropped === 1'b1) drop_cnt <= drop_cnt + 1;

  function automatic logic [SIZE-1:0] model(input logic [SIZE-1:0] v, input logic f);
    logic [SIZE-1:0] op;
    logic [SIZE-1:0] r;
    op = f ? {{(SIZE-FLOAT_SIZE){1'b0}}, v[FLOAT_SIZE-1:0]} : v;
    r  = op ^ 64'hFF;
    if (f) r[SIZE-1:FLOAT_SIZE] = '0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (isResultStable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_ack();
    resultAck = 1'b1;
    tick();
    resultAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    isInputStable = 1'b0; op_in = '0; isFloat = 1'b0; resultAck = 1'b0;
    tick(); tick();
    checks++;
    if ({result, coreIn} !== '0) begin
      errors++; $display("FAIL reset_data: result=%h coreIn=%h want 0", result, coreIn);
    end
    checks++;
    if ({isResultStable, coreStart, coreIsFloat, busy, reqDropped} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: flags=%b want 00000",
                         {isResultStable, coreStart, coreIsFloat, busy, reqDropped});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_integer();
    logic [SIZE-1:0] exp;
    // Stray ack while idle has no effect.
    resultAck = 1'b1; tick(); resultAck = 1'b0;
    checks++;
    if ({busy, isResultStable} !== 2'b00) begin
      errors++; $display("FAIL idle_ack: busy/valid=%b want 00", {busy, isResultStable});
    end
    isInputStable = 1'b1; op_in = 64'h0000_0001_0000_0000; isFloat = 1'b0;
    sb.push_back(model(op_in, isFloat));
    tick();                                   // N+1
    isInputStable = 1'b0; op_in = '0;
    checks++;
    if (coreStart !== 1'b1 || coreIn !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL int_launch: coreStart=%b coreIn=%h want 1 0000000100000000", coreStart, coreIn);
    end
    tick();                                   // N+2
    checks++;
    if (coreStart !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL int_start_pulse: coreStart=%b busy=%b want 0 1", coreStart, busy);
    end
    tick(); tick();                           // N+4
    checks++;
    if (isResultStable !== 1'b0) begin
      errors++; $display("FAIL int_early_valid: isResultStable=%b want 0", isResultStable);
    end
    tick();                                   // N+5
    exp = sb.pop_front();
    checks++;
    if (isResultStable !== 1'b1 || result !== exp) begin
      errors++; $display("FAIL int_result: valid=%b result=%h want 1 %h", isResultStable, result, exp);
    end
    checks++;
    if (exp !== 64'h0000_0001_0000_00FF) begin
      errors++; $display("FAIL int_model: got %h want 00000001000000ff", exp);
    end
    tick();
    checks++;
    if (isResultStable !== 1'b1 || result !== exp) begin
      errors++; $display("FAIL int_hold: valid=%b result=%h want 1 %h", isResultStable, result, exp);
    end
    do_ack();
    checks++;
    if (isResultStable !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++; $display("FAIL int_after_ack: valid=%b busy=%b result=%h want 0 0 %h",
                         isResultStable, busy, result, exp);
    end
  endtask

  task automatic test_float();
    bit ok;
    logic [SIZE-1:0] exp;
    isInputStable = 1'b1; op_in = 64'hDEAD_BEEF_4080_0000; isFloat = 1'b1;
    sb.push_back(model(op_in, isFloat));
    tick();
    isInputStable = 1'b0; isFloat = 1'b0; op_in = '0;
    checks++;
    if (coreIn !== 64'h0000_0000_4080_0000 || coreIsFloat !== 1'b1) begin
      errors++; $display("FAIL flt_corein: coreIn=%h isFloat=%b want 0000000040800000 1", coreIn, coreIsFloat);
    end
    tick();
    checks++;
    if (coreIn !== 64'h0000_0000_4080_0000 || coreIsFloat !== 1'b1) begin
      errors++; $display("FAIL flt_corein_stable: coreIn=%h isFloat=%b want 0000000040800000 1", coreIn, coreIsFloat);
    end
    wait_result(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || result !== exp || exp !== 64'h0000_0000_4080_00FF) begin
      errors++; $display("FAIL flt_result: ok=%0d result=%h want 00000000408000ff", ok, result);
    end
    do_ack();
  endtask

  task automatic test_delayed_ack();
    bit ok;
    logic [SIZE-1:0] exp;
    isInputStable = 1'b1; op_in = 64'hA5A5_0000_1234_5678; isFloat = 1'b0;
    sb.push_back(model(op_in, isFloat));
    tick();
    isInputStable = 1'b0;
    wait_result(ok);
    exp = sb.pop_front();
    checks++;
    if (!ok || result !== exp) begin
      errors++; $display("FAIL dly_result: ok=%0d result=%h want %h", ok, result, exp);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (isResultStable !== 1'b1 || result !== exp) begin
        errors++; $display("FAIL dly_hold_%0d: valid=%b result=%h want 1 %h", i, isResultStable, result, exp);
      end
    end
    do_ack();
    checks++;
    if (isResultStable !== 1'b0) begin
      errors++; $display("FAIL dly_ack_drop: valid=%b want 0", isResultStable);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int drop_base;
    int exp_drops;
    logic [SIZE-1:0] vals [4];
    logic            flts [4];
    vals[0] = 64'h0000_0000_0000_1234; flts[0] = 1'b0;
    vals[1] = 64'h5555_0000_0000_0001; flts[1] = 1'b0;
    vals[2] = 64'hFFFF_FFFF_3F80_0000; flts[2] = 1'b1;
    vals[3] = 64'h0000_0000_0000_0077; flts[3] = 1'b0;
    drop_base = drop_cnt;
`ifdef SQRT_REQ_QUEUE_EN
    exp_drops = 1;
`else
    exp_drops = 3;
`endif
    for (int i = 0; i < 4; i++) begin
      isInputStable = 1'b1; op_in = vals[i]; isFloat = flts[i];
`ifdef SQRT_REQ_QUEUE_EN
      if (i < 3) sb.push_back(model(vals[i], flts[i]));
`else
      if (i == 0) sb.push_back(model(vals[i], flts[i]));
`endif
      tick();
    end
    isInputStable = 1'b0; isFloat = 1'b0; op_in = '0;
    while (sb.size() > 0) begin
      logic [SIZE-1:0] exp;
      wait_result(ok);
      exp = sb.pop_front();
      checks++;
      if (!ok || result !== exp) begin
        errors++; $display("FAIL b2b_result: ok=%0d result=%h want %h", ok, result, exp);
      end
      do_ack();
    end
    tick(); tick();
    checks++;
    if (drop_cnt - drop_base !== exp_drops) begin
      errors++; $display("FAIL b2b_drops: pulses=%0d want %0d", drop_cnt - drop_base, exp_drops);
    end
    checks++;
    if (busy !== 1'b0 || isResultStable !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b valid=%b want 0 0", busy, isResultStable);
    end
  endtask

  task automatic test_reset_midflight();
    isInputStable = 1'b1; op_in = 64'h0000_0000_0000_0F0F; isFloat = 1'b1;
    tick();
    isInputStable = 1'b0; isFloat = 1'b0; op_in = '0;
    tick();                                   // WAIT_CORE
    checks++;
    if (busy !== 1'b1 || coreStart !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: busy=%b coreStart=%b want 1 0", busy, coreStart);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({result, coreIn, isResultStable, coreStart, coreIsFloat, busy, reqDropped} !== '0) begin
      errors++; $display("FAIL rst_mid_zero: result=%h coreIn=%h flags=%b want all 0", result, coreIn,
                         {isResultStable, coreStart, coreIsFloat, busy, reqDropped});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (isResultStable !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_ignore_%0d: valid=%b busy=%b want 0 0", i, isResultStable, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_float();
    test_delayed_ack();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sqrt_handshake_responder.md
SQRT_HANDSHAKE_RESPONDER -- requirements
Module: sqrt_handshake_responder

Interface
REQ-001 SHALL have parameter SIZE, default 64: operand/result width in bits.
REQ-002 SHALL have parameter FLOAT_SIZE, default 32: width of a single-precision operand (low bits of in/result).
REQ-003 SHALL have port clk, input, 1: sole clock; one clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port isInputStable, input, 1: requester strobe; in/isFloat valid in the cycle it is high.
REQ-006 SHALL have port in, input, SIZE: operand.
REQ-007 SHALL have port isFloat, input, 1: 1 = float operand in in[FLOAT_SIZE-1:0]; 0 = SIZE-bit unsigned integer.
REQ-008 SHALL have port result, output, SIZE: registered square-root result.
REQ-009 SHALL have port isResultStable, output, 1: result valid; held until acknowledged.
REQ-010 SHALL have port resultAck, input, 1: requester acknowledge of the held result.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port reqDropped, output, 1: one-cycle pulse when a request is discarded.
REQ-013 SHALL have ports coreStart (output, 1), coreIn (output, SIZE), coreIsFloat (output, 1), coreDone (input, 1), coreResult (input, SIZE): the core-side start/done interface.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_CORE, HOLD_RESULT.
REQ-015 IDLE: isInputStable sampled high at cycle N -> capture in/isFloat, go to LAUNCH; coreStart SHALL be high for exactly cycle N+1.
REQ-016 When isFloat=1, coreIn SHALL carry in[FLOAT_SIZE-1:0] zero-extended; the upper input bits SHALL be ignored.
REQ-017 LAUNCH SHALL go to WAIT_CORE unconditionally after one cycle; coreIn/coreIsFloat SHALL stay stable from LAUNCH through WAIT_CORE.
REQ-018 WAIT_CORE: coreDone high at cycle M -> latch coreResult; go to HOLD_RESULT; isResultStable SHALL rise at M+1.
REQ-019 For float requests, result[SIZE-1:FLOAT_SIZE] SHALL be forced to zero.
REQ-020 HOLD_RESULT: result and isResultStable SHALL be held until resultAck is sampled high; isResultStable SHALL be low in the following cycle.
REQ-021 resultAck outside HOLD_RESULT SHALL be ignored; coreDone outside WAIT_CORE SHALL be ignored.
REQ-022 resultAck and isInputStable high in the same HOLD_RESULT cycle SHALL count as an ack plus a request arriving while busy (see REQ-026/027).
REQ-023 After ack: pending queued request -> LAUNCH next cycle; otherwise -> IDLE.
REQ-024 result SHALL retain its last value after ack until overwritten by the next coreDone.

Reset
REQ-025 rst high SHALL, on the next edge and from any state: set state IDLE, result=0, isResultStable=0, coreStart=0, coreIn=0, coreIsFloat=0, busy=0, reqDropped=0, and empty the queue; an in-flight core operation SHALL be abandoned, and its later coreDone ignored.

Configuration
REQ-026 With SQRT_REQ_QUEUE_EN defined: a 2-entry FIFO SHALL accept isInputStable while busy; requests SHALL be launched in arrival order; a request arriving with the FIFO full SHALL be discarded with reqDropped pulsed.
REQ-027 Without SQRT_REQ_QUEUE_EN: isInputStable while busy SHALL be discarded with reqDropped pulsed; no queue storage SHALL exist.

Verification (core stub: coreDone 3 cycles after coreStart, coreResult = coreIn ^ 64'hFF)
REQ-028 Integer in=64'h0000_0001_0000_0000, isFloat=0 -> coreStart at N+1, isResultStable at N+5, result=64'h0000_0001_0000_00FF, held until ack.
REQ-029 Float in=64'hDEAD_BEEF_4080_0000, isFloat=1 -> coreIn=64'h0000_0000_4080_0000; result=64'h0000_0000_4080_00FF.
REQ-030 Ack delayed 20 cycles -> result/isResultStable stable all 20 cycles; isResultStable low the cycle after ack.
REQ-031 Three back-to-back strobes while busy -> with SQRT_REQ_QUEUE_EN: two served in order, third dropped with one reqDropped pulse; without: all three dropped, three pulses.
REQ-032 rst asserted in WAIT_CORE -> IDLE and all outputs zero next cycle; the stub's later coreDone produces no isResultStable.
